// File: rtl/gpio_debounce.sv
// gpio_debounce
//   Per-pin debouncer for raw GPIO inputs. Each pin goes through a two-flop
//   synchronizer. A pin's debounced level changes only after the synchronized
//   level has disagreed with it for a programmable number of consecutive
//   clocks. Commits raise sticky RISE/FALL flags, and those flags drive a
//   maskable level interrupt.
//
// Ports
//   clk          rising-edge clock for all logic
//   rst          synchronous active-high reset
//   pins_in      raw asynchronous pins (WIDTH)
//   pins_stable  debounced pin levels (WIDTH)
//   r_en/r_addr  read strobe and address; r_data is registered one clock later
//   w_en/w_addr/w_data  write strobe, address and data
//   irq          registered level interrupt
//
// Register map (address bits [7:0] only)
//   0x00 STATE   RO   debounced levels
//   0x04 RISE    W1C  0->1 commit flags
//   0x08 FALL    W1C  1->0 commit flags
//   0x0C THRESH  RW   debounce threshold [CNT_W-1:0]; 0 behaves as 1
//   0x10 IRQ_EN  RW   [WIDTH-1:0] rise enables, [2*WIDTH-1:WIDTH] fall enables
module gpio_debounce #(
  parameter int              WIDTH      = 8,
  parameter int              CNT_W      = 16,
  parameter logic [CNT_W-1:0] THRESH_RST = 16'd1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_stable,
  input  logic             r_en,
  input  logic [31:0]      r_addr,
  output logic [31:0]      r_data,
  input  logic             w_en,
  input  logic [31:0]      w_addr,
  input  logic [31:0]      w_data,
  output logic             irq
);

  localparam logic [7:0] ADDR_STATE  = 8'h00;
  localparam logic [7:0] ADDR_RISE   = 8'h04;
  localparam logic [7:0] ADDR_FALL   = 8'h08;
  localparam logic [7:0] ADDR_THRESH = 8'h0C;
  localparam logic [7:0] ADDR_IRQ_EN = 8'h10;

  logic [WIDTH-1:0]   sync1_q, sync2_q;
  logic [WIDTH-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0]   cnt_q [WIDTH];
  logic [CNT_W-1:0]   cnt_d [WIDTH];
  logic [CNT_W:0]     cnt_inc [WIDTH];
  logic [WIDTH-1:0]   rise_q, rise_d, fall_q, fall_d;
  logic [WIDTH-1:0]   set_rise, set_fall;
  logic [CNT_W-1:0]   thresh_q, thresh_eff;
  logic [2*WIDTH-1:0] irq_en_q;
  logic               irq_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               wr_rise, wr_fall, wr_thresh, wr_irq_en;
  logic               unused_addr_data;

  // Only the low address byte and the low data bits are decoded.
  assign unused_addr_data = ^{r_addr, w_addr, w_data};

  assign wr_rise   = w_en && (w_addr[7:0] == ADDR_RISE);
  assign wr_fall   = w_en && (w_addr[7:0] == ADDR_FALL);
  assign wr_thresh = w_en && (w_addr[7:0] == ADDR_THRESH);
  assign wr_irq_en = w_en && (w_addr[7:0] == ADDR_IRQ_EN);

  assign thresh_eff = (thresh_q == '0) ? CNT_W'(1) : thresh_q;

  // One extra bit so an all-ones count still compares correctly.
  for (genvar g = 0; g < WIDTH; g++) begin : g_inc
    assign cnt_inc[g] = {1'b0, cnt_q[g]} + (CNT_W+1)'(1);
  end

  // An all-ones count always meets any threshold, so the commit branch
  // fires before the counter could wrap; that is the saturation.
  always_comb begin
    stable_d = stable_q;
    set_rise = '0;
    set_fall = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_inc[i] >= {1'b0, thresh_eff}) begin
          stable_d[i] = sync2_q[i];
          set_rise[i] = sync2_q[i];
          set_fall[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_inc[i][CNT_W-1:0];
        end
      end
    end
  end

  // A same-cycle commit wins over a W1C clear.
  assign rise_d = (rise_q & ~(wr_rise ? w_data[WIDTH-1:0] : '0)) | set_rise;
  assign fall_d = (fall_q & ~(wr_fall ? w_data[WIDTH-1:0] : '0)) | set_fall;

  // Reads see pre-write register values.
  always_comb begin
    rdata_d = '0;
    if (r_en) begin
      case (r_addr[7:0])
        ADDR_STATE:  rdata_d = 32'(stable_q);
        ADDR_RISE:   rdata_d = 32'(rise_q);
        ADDR_FALL:   rdata_d = 32'(fall_q);
        ADDR_THRESH: rdata_d = 32'(thresh_q);
        ADDR_IRQ_EN: rdata_d = 32'(irq_en_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      thresh_q <= THRESH_RST;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      sync1_q  <= pins_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      if (wr_thresh) thresh_q <= w_data[CNT_W-1:0];
      if (wr_irq_en) irq_en_q <= w_data[2*WIDTH-1:0];
      irq_q    <= |((rise_q & irq_en_q[WIDTH-1:0]) |
                    (fall_q & irq_en_q[2*WIDTH-1:WIDTH]));
      rdata_q  <= rdata_d;
    end
  end

  assign pins_stable = stable_q;
  assign r_data      = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce
//   Directed bench for gpio_debounce (WIDTH=8, CNT_W=16). A behavioural model
//   tracks, per pin, how many consecutive clocks the synchronized level has
//   disagreed with the debounced level, plus the register file. Every falling
//   edge compares pins_stable, irq and r_data against it. Scenario checks
//   compare against hand-computed literals.
module tb_gpio_debounce;

  logic        clk;
  logic        rst;
  logic [7:0]  pins_in;
  logic [7:0]  pins_stable;
  logic        r_en;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  gpio_debounce #(.WIDTH(8), .CNT_W(16), .THRESH_RST(16'd1000)) dut (
    .clk(clk), .rst(rst), .pins_in(pins_in), .pins_stable(pins_stable),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]  m_s1, m_s2, m_stable, m_rise, m_fall;
  logic [15:0] m_thresh, m_irq_en;
  logic        m_irq;
  logic [31:0] m_rdata;
  int          run [8];

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return {24'd0, m_stable};
      8'h04:   return {24'd0, m_rise};
      8'h08:   return {24'd0, m_fall};
      8'h0C:   return {16'd0, m_thresh};
      8'h10:   return {16'd0, m_irq_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int         eff;
    logic [7:0] seen, nr, nf, cr, cf;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_rise = 0; m_fall = 0;
      m_thresh = 16'd1000; m_irq_en = 0; m_irq = 0; m_rdata = 0;
      for (int i = 0; i < 8; i++) run[i] = 0;
    end else begin
      m_rdata = r_en ? m_read(r_addr[7:0]) : 32'd0;
      m_irq   = |((m_rise & m_irq_en[7:0]) | (m_fall & m_irq_en[15:8]));
      eff     = (m_thresh == 16'd0) ? 1 : int'(m_thresh);
      seen = m_s2; m_s2 = m_s1; m_s1 = pins_in;
      nr = 0; nf = 0;
      for (int i = 0; i < 8; i++) begin
        if (seen[i] == m_stable[i]) run[i] = 0;
        else begin
          run[i] = run[i] + 1;
          if (run[i] >= eff) begin
            if (seen[i]) nr[i] = 1'b1; else nf[i] = 1'b1;
            m_stable[i] = seen[i];
            run[i] = 0;
          end
        end
      end
      cr = (w_en && w_addr[7:0] == 8'h04) ? w_data[7:0] : 8'h00;
      cf = (w_en && w_addr[7:0] == 8'h08) ? w_data[7:0] : 8'h00;
      m_rise = (m_rise & ~cr) | nr;
      m_fall = (m_fall & ~cf) | nf;
      if (w_en && w_addr[7:0] == 8'h0C) m_thresh = w_data[15:0];
      if (w_en && w_addr[7:0] == 8'h10) m_irq_en = w_data[15:0];
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model_pins_stable", {24'd0, pins_stable}, {24'd0, m_stable});
      chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
      chk("model_r_data", r_data, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    w_en = 1'b1; w_addr = a; w_data = d;
    @(negedge clk);
    w_en = 1'b0; w_addr = 0; w_data = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    r_en = 1'b1; r_addr = a;
    @(negedge clk);
    chk(nm, r_data, exp);
    r_en = 1'b0; r_addr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pins_in = 0; r_en = 0; r_addr = 0; w_en = 0; w_addr = 0; w_data = 0;
    @(negedge clk);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_pins_stable", {24'd0, pins_stable}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_r_data", r_data, 32'd0);
    rd_chk("rst_thresh", 32'h0C, 32'd1000);

    // Glitch of 3 synchronized clocks against threshold 4.
    wr(32'h0C, 32'd4);
    pins_in[3] = 1'b1;
    step(3);
    pins_in[3] = 1'b0;
    step(8);
    chk("glitch_stable", {24'd0, pins_stable}, 32'd0);
    rd_chk("glitch_rise", 32'h04, 32'd0);
    rd_chk("glitch_fall", 32'h08, 32'd0);

    // Clean rise on pin 0: commit six clocks after the change, irq one later.
    wr(32'h10, 32'h0001);
    pins_in[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) chk("rise_before_commit", {31'd0, pins_stable[0]}, 32'd0);
      if (k == 6) begin
        chk("rise_commit", {31'd0, pins_stable[0]}, 32'd1);
        chk("irq_lag", {31'd0, irq}, 32'd0);
      end
      if (k == 7) chk("irq_set", {31'd0, irq}, 32'd1);
    end
    rd_chk("rise_flag", 32'h04, 32'h01);

    // W1C on RISE, then a commit colliding with the clear.
    pins_in[2] = 1'b1;
    step(8);
    rd_chk("rise_two", 32'h04, 32'h05);
    wr(32'h04, 32'h04);
    rd_chk("rise_w1c", 32'h04, 32'h01);
    pins_in[2] = 1'b0;
    step(8);
    rd_chk("fall_flag", 32'h08, 32'h04);
    pins_in[2] = 1'b1;
    step(5);
    wr(32'h04, 32'h04);
    rd_chk("set_beats_clear", 32'h04, 32'h05);
    wr(32'h04, 32'hFF);
    wr(32'h08, 32'hFF);
    step(1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // Register reads, ignored writes, read/write collision.
    pins_in = 8'hA5;
    step(8);
    wr(32'h10, 32'h0102);
    wr(32'h00, 32'hFF);
    wr(32'h14, 32'hFFFF);
    rd_chk("read_state", 32'h00, 32'h000000A5);
    rd_chk("read_irq_en", 32'h10, 32'h00000102);
    rd_chk("read_unmapped", 32'h14, 32'h00000000);
    step(1);
    chk("r_data_idle", r_data, 32'd0);
    rd_chk("read_high_addr_bits", 32'hFFFF_FF00, 32'h000000A5);
    r_en = 1'b1; r_addr = 32'h10; w_en = 1'b1; w_addr = 32'h10; w_data = 32'h3;
    @(negedge clk);
    chk("read_during_write", r_data, 32'h00000102);
    r_en = 1'b0; w_en = 1'b0; r_addr = 0; w_addr = 0; w_data = 0;
    rd_chk("read_after_write", 32'h10, 32'h00000003);

    // THRESH=0 behaves as one clock: latency 3.
    wr(32'h0C, 32'd0);
    pins_in[1] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 2) chk("fast_before", {31'd0, pins_stable[1]}, 32'd0);
      if (k == 3) chk("fast_commit", {31'd0, pins_stable[1]}, 32'd1);
    end
    rd_chk("thresh_zero", 32'h0C, 32'd0);

    // Reset at count 2 of 4 with pin 0 held high.
    pins_in = 8'h00;
    step(4);
    chk("all_low", {24'd0, pins_stable}, 32'd0);
    wr(32'h0C, 32'd4);
    pins_in[0] = 1'b1;
    step(4);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_stable", {24'd0, pins_stable}, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    chk("midrst_r_data", r_data, 32'd0);
    rst = 1'b0;
    wr(32'h0C, 32'd4);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) chk("post_rst_before", {31'd0, pins_stable[0]}, 32'd0);
      if (k == 6) chk("post_rst_commit", {31'd0, pins_stable[0]}, 32'd1);
    end
    rd_chk("post_rst_rise", 32'h04, 32'h01);
    rd_chk("post_rst_fall", 32'h08, 32'h00);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
